// File: rtl/pong_pkg.sv
// Shared pong definitions: screen geometry, AI state encoding and signed clamp helper.
package pong_pkg;

  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    AI_RECENTER = 2'd0,
    AI_REACT    = 2'd1,
    AI_TRACK    = 2'd2,
    AI_UNUSED   = 2'd3
  } ai_state_e;

  // When hi < lo the lower bound wins, pinning the paddle to the top wall.
  function automatic coord_t clamp_s(input coord_t v, input coord_t lo, input coord_t hi);
    coord_t r;
    r = v;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-level debounce counter for one push-button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: debounced player paddle on the right, tracking AI paddle on the left.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned RESET_Y         = 200,
  parameter int unsigned PLAYER_SPEED    = 4,
  parameter int unsigned AI_SPEED        = 3,
  parameter int unsigned DEAD_ZONE       = 4,
  parameter int unsigned REACT_TICKS     = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [8:0] ball_y,
  input  logic [5:0] ball_width,
  input  logic       ball_direction,
  input  logic [5:0] wall_width,
  input  logic [8:0] paddle_length,
  output logic [8:0] paddle_l_y,
  output logic [8:0] paddle_r_y,
  output logic [1:0] ai_state
);

  localparam int unsigned Y_W     = 9;
  localparam int unsigned REACT_W = (REACT_TICKS < 2) ? 1 : $clog2(REACT_TICKS + 1);

  logic               w_up;
  logic               w_down;
  coord_t             w_y_min;
  coord_t             w_y_max;
  coord_t             w_len;
  coord_t             w_target;
  coord_t             w_centre;
  coord_t             w_l_cur;
  coord_t             w_r_cur;
  coord_t             w_r_step;
  coord_t             w_r_nxt;
  coord_t             w_l_nxt;
  coord_t             w_l_diff;
  logic               w_l_far;
  ai_state_e          r_state;
  ai_state_e          w_state_nxt;
  logic [REACT_W-1:0] r_react;
  logic [REACT_W-1:0] w_react_nxt;
  logic [Y_W-1:0]     r_l_y;
  logic [Y_W-1:0]     r_r_y;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_up (
    .clk(clk), .rst_n(reset), .i_btn(btn_up), .o_level(w_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_down (
    .clk(clk), .rst_n(reset), .i_btn(btn_down), .o_level(w_down)
  );

  // Move y toward tgt by at most spd without overshooting.
  function automatic coord_t step_toward(input coord_t y, input coord_t tgt, input coord_t spd);
    if (tgt - y > spd)      return y + spd;
    else if (y - tgt > spd) return y - spd;
    else                    return tgt;
  endfunction

  assign w_len    = coord_t'({2'b00, paddle_length});
  assign w_y_min  = coord_t'({5'b00000, wall_width});
  assign w_y_max  = coord_t'(SCREEN_H) - w_y_min - w_len;
  assign w_target = clamp_s(coord_t'({2'b00, ball_y}) + (coord_t'({5'b00000, ball_width}) >>> 1)
                            - (w_len >>> 1), w_y_min, w_y_max);
  assign w_centre = clamp_s((coord_t'(SCREEN_H) - w_len) >>> 1, w_y_min, w_y_max);
  assign w_l_cur  = coord_t'({2'b00, r_l_y});
  assign w_r_cur  = coord_t'({2'b00, r_r_y});
  assign w_l_diff = w_target - w_l_cur;
  assign w_l_far  = (w_l_diff > coord_t'(DEAD_ZONE)) || (w_l_diff < -coord_t'(DEAD_ZONE));

  // Player paddle: opposing buttons cancel; clamping runs on every tick.
  always_comb begin
    w_r_step = w_r_cur;
    w_r_nxt  = w_r_cur;
    if (w_up && !w_down)      w_r_step = w_r_cur - coord_t'(PLAYER_SPEED);
    else if (w_down && !w_up) w_r_step = w_r_cur + coord_t'(PLAYER_SPEED);
    if (tick) w_r_nxt = clamp_s(w_r_step, w_y_min, w_y_max);
  end

  // AI next-state and move; the move is decided by the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_react_nxt = r_react;
    w_l_nxt     = w_l_cur;
    case (r_state)
      AI_RECENTER: begin
        if (tick) begin
          w_l_nxt = clamp_s(step_toward(w_l_cur, w_centre, coord_t'(AI_SPEED)), w_y_min, w_y_max);
          if (ball_direction) begin
            if (REACT_TICKS == 0) begin
              w_state_nxt = AI_TRACK;
            end else begin
              w_state_nxt = AI_REACT;
              w_react_nxt = REACT_W'(REACT_TICKS);
            end
          end
        end
      end
      AI_REACT: begin
        if (tick) begin
          if (!ball_direction) begin
            w_state_nxt = AI_RECENTER;
          end else if (r_react <= REACT_W'(1)) begin
            w_state_nxt = AI_TRACK;
            w_react_nxt = '0;
          end else begin
            w_react_nxt = r_react - REACT_W'(1);
          end
        end
      end
      AI_TRACK: begin
        if (tick) begin
          if (w_l_far)
            w_l_nxt = clamp_s(step_toward(w_l_cur, w_target, coord_t'(AI_SPEED)), w_y_min, w_y_max);
          if (!ball_direction) w_state_nxt = AI_RECENTER;
        end
      end
      default: w_state_nxt = AI_RECENTER;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= AI_RECENTER;
      r_react <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_react <= w_react_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_l_y <= Y_W'(RESET_Y);
      r_r_y <= Y_W'(RESET_Y);
    end else begin
      r_l_y <= Y_W'(w_l_nxt);
      r_r_y <= Y_W'(w_r_nxt);
    end
  end

  assign paddle_l_y = r_l_y;
  assign paddle_r_y = r_r_y;
  assign ai_state   = r_state;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with a behavioural model feeding an expected-value queue.
module tb_paddle_ctrl;

  localparam int SCR   = 480;
  localparam int RST_Y = 200;
  localparam int PSPD  = 4;
  localparam int ASPD  = 3;
  localparam int DZ    = 4;
  localparam int RT    = 6;

  logic       clk = 1'b0;
  logic       reset, tick, btn_up, btn_down, ball_direction;
  logic [8:0] ball_y, paddle_length;
  logic [5:0] ball_width, wall_width;
  logic [8:0] paddle_l_y, paddle_r_y;
  logic [1:0] ai_state;

  always #5 clk = ~clk;

  paddle_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_up(btn_up), .btn_down(btn_down),
    .ball_y(ball_y), .ball_width(ball_width), .ball_direction(ball_direction),
    .wall_width(wall_width), .paddle_length(paddle_length),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ai_state(ai_state)
  );

  typedef struct { string tag; int sel; int exp; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int m_l, m_r, m_st, m_cnt;
  bit m_up, m_down;

  function automatic int clampi(int v, int lo, int hi);
    int r;
    r = v;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  function automatic int toward(int y, int tgt, int spd);
    if (tgt - y > spd) return y + spd;
    if (y - tgt > spd) return y - spd;
    return tgt;
  endfunction

  function automatic logic [8:0] obs(int sel);
    case (sel)
      0:       return paddle_l_y;
      1:       return paddle_r_y;
      default: return {7'd0, ai_state};
    endcase
  endfunction

  task automatic model_reset();
    m_l = RST_Y; m_r = RST_Y; m_st = 0; m_cnt = 0; m_up = 0; m_down = 0;
  endtask

  // One tick of the reference behaviour, using the inputs currently driven.
  task automatic model_tick();
    int lo, hi, tgt, ctr, c, d;
    lo  = int'(wall_width);
    hi  = SCR - int'(wall_width) - int'(paddle_length);
    tgt = clampi(int'(ball_y) + int'(ball_width) / 2 - int'(paddle_length) / 2, lo, hi);
    ctr = clampi((SCR - int'(paddle_length)) >>> 1, lo, hi);
    c = m_r;
    if (m_up && !m_down) c = m_r - PSPD;
    else if (m_down && !m_up) c = m_r + PSPD;
    m_r = clampi(c, lo, hi);
    case (m_st)
      0: begin
        m_l = clampi(toward(m_l, ctr, ASPD), lo, hi);
        if (ball_direction) begin
          if (RT == 0) m_st = 2;
          else begin m_st = 1; m_cnt = RT; end
        end
      end
      1: begin
        if (!ball_direction) m_st = 0;
        else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_st = 2;
        end
      end
      default: begin
        d = tgt - m_l;
        if (d > DZ || d < -DZ) m_l = clampi(toward(m_l, tgt, ASPD), lo, hi);
        if (!ball_direction) m_st = 0;
      end
    endcase
  endtask

  task automatic push_exp(string tag, int sel, int exp);
    sb.push_back('{tag, sel, exp});
  endtask

  task automatic push_model(string tag);
    push_exp({tag, "_l"}, 0, m_l);
    push_exp({tag, "_r"}, 1, m_r);
    push_exp({tag, "_st"}, 2, m_st);
  endtask

  task automatic drain();
    exp_t       e;
    logic [8:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = obs(e.sel);
      checks++;
      assert (act === 9'(e.exp)) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, act, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic do_tick(string tag);
    model_tick();
    push_model(tag);
    tick = 1'b1;
    step();
    tick = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; ball_direction = 1'b0;
    ball_y = 9'd50; ball_width = 6'd8; wall_width = 6'd10; paddle_length = 9'd80;
    model_reset();
    #2 reset = 1'b0;
    #1 push_model("in_rst"); drain();
    idle(3);
    reset = 1'b1;
    idle(100);
    push_exp("idle_l", 0, 200); push_exp("idle_r", 1, 200); push_exp("idle_st", 2, 0); drain();

    // Short presses must never be accepted.
    repeat (3) begin
      btn_up = 1'b1; idle(10);
      btn_up = 1'b0; idle(3);
      do_tick("glitch");
    end
    idle(4);

    // Press latency: accepted level changes on the 18th edge after the press.
    btn_up = 1'b1;
    idle(17);
    do_tick("lat18");
    m_up = 1'b1;
    do_tick("lat19");
    push_exp("lat19_r196", 1, 196); drain();
    repeat (50) begin do_tick("up"); idle(1); end
    push_exp("up_clamp", 1, 10); drain();

    btn_down = 1'b1; idle(20); m_down = 1'b1;
    repeat (3) do_tick("both");
    push_exp("both_hold", 1, 10); drain();

    btn_up = 1'b0; idle(20); m_up = 1'b0;
    repeat (100) do_tick("down");
    push_exp("down_clamp", 1, 390); drain();

    wall_width = 6'd20;
    do_tick("snap");
    push_exp("snap_r", 1, 380); drain();
    wall_width = 6'd10;

    ball_direction = 1'b1;
    repeat (6) do_tick("react");
    push_exp("react_st", 2, 1); push_exp("react_hold_l", 0, 200); drain();
    do_tick("to_track");
    push_exp("track_st", 2, 2); drain();
    repeat (70) do_tick("track");
    push_exp("track_settle", 0, 17); drain();

    ball_direction = 1'b0;
    do_tick("leave");
    push_exp("leave_st", 2, 0); push_exp("leave_l", 0, 17); drain();
    repeat (65) do_tick("recenter");
    push_exp("recenter_l", 0, 200); drain();

    paddle_length = 9'd470;
    do_tick("degen");
    push_exp("degen_l", 0, 10); push_exp("degen_r", 1, 10); drain();
    paddle_length = 9'd80;

    ball_y = 9'd300; ball_direction = 1'b1;
    repeat (12) do_tick("pre_rst");
    push_exp("pre_rst_st", 2, 2); drain();

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1 model_reset();
    push_exp("async_l", 0, 200); push_exp("async_r", 1, 200); push_exp("async_st", 2, 0); drain();
    idle(2);
    reset = 1'b1;
    do_tick("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Produces the two paddle Y positions consumed by the ball stage. Right paddle is the human player, driven by raw up/down push-buttons (synchronised and debounced here). Left paddle is the computer opponent, driven by a small tracking state machine fed from the ball stage's Y position and direction. All motion is applied once per movement strobe (tick), clamped between the top and bottom walls.

Parameters:
SCREEN_H, 480, visible lines; bottom wall reference
RESET_Y, 200, paddle Y (upper edge) loaded at reset
PLAYER_SPEED, 4, pixels per tick for the right paddle
AI_SPEED, 3, pixels per tick for the left paddle
DEAD_ZONE, 4, AI holds when |target - paddle_l_y| <= DEAD_ZONE
REACT_TICKS, 6, ticks the AI waits after the ball turns toward it
DEBOUNCE_CYCLES, 16, consecutive stable clocks required to accept a button level (4..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
tick  in  1  one-clock movement strobe (once per frame)
btn_up  in  1  raw right-player up button, asynchronous
btn_down  in  1  raw right-player down button, asynchronous
ball_y  in  9  ball upper-edge Y
ball_width  in  6  ball side length
ball_direction  in  1  1 = ball moving left (toward AI), 0 = moving right
wall_width  in  6  top/bottom wall thickness
paddle_length  in  9  paddle height
paddle_l_y  out  9  left (AI) paddle upper-edge Y
paddle_r_y  out  9  right (player) paddle upper-edge Y
ai_state  out  2  current AI state (debug/LED)

Behaviour:
- Reset (reset=0, async): paddle_l_y = paddle_r_y = RESET_Y; ai_state = RECENTER; debounced buttons = 0; debounce counters = 0; react counter = 0; synchronisers = 0.
- Limits: y_min = wall_width; y_max = SCREEN_H - wall_width - paddle_length. Compute in 11-bit signed. If y_max < y_min, both paddles are held at y_min.
- Button path: 2-flop synchroniser per button, then debounce. A counter increments while the synced level differs from the accepted level; the counter resets when the levels agree. When it reaches DEBOUNCE_CYCLES-1, the accepted level takes the synced value and the counter clears.
- Input latency: a clean press becomes visible after exactly 2 + DEBOUNCE_CYCLES clocks.
- Right paddle updates only on a clock with tick=1:
  - up only: y = max(y - PLAYER_SPEED, y_min)
  - down only: y = min(y + PLAYER_SPEED, y_max)
  - both or neither: hold
- Clamping also applies with no button pressed. A position outside [y_min, y_max] (after a wall_width or paddle_length change) snaps into range on the next tick.
- AI target: target = ball_y + (ball_width>>1) - (paddle_length>>1), signed, clamped to [y_min, y_max]. Centre target = clamp((SCREEN_H - paddle_length)>>1).
- AI FSM, all transitions and moves evaluated only on tick=1:
  - RECENTER (2'd0): step toward the centre target by at most AI_SPEED, never overshooting. If ball_direction=1: load react counter = REACT_TICKS, go to REACT.
  - REACT (2'd1): hold position; decrement the counter. When the counter reaches 0, go to TRACK. If ball_direction=0: go to RECENTER.
  - TRACK (2'd2): if |target - y| > DEAD_ZONE, step toward target by min(AI_SPEED, |target - y|); else hold. If ball_direction=0: go to RECENTER.
  - 2'd3 is unused; it recovers to RECENTER on the next clock.
- With REACT_TICKS=0, RECENTER goes straight to TRACK.
- Moves and state change on the same tick: the move uses the current state; the new state takes effect from the next tick.
- Outputs are registered; paddle positions change on the clock edge after a tick.
- Reset asserted mid-motion restores all reset values immediately; first movement occurs on the first tick after release.

Decomposition:
- Shared package pong_pkg holds: SCREEN_H; AI state encoding (AI_RECENTER=0, AI_REACT=1, AI_TRACK=2); the signed clamp helper function. The ball stage reuses SCREEN_H.
- One sub-module: btn_debounce (synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan:
- Reset then release, no ticks -> paddle_l_y=200, paddle_r_y=200, ai_state=0, held for 100 clocks.
- Hold btn_up, 10-cycle glitches and then steady (DEBOUNCE_CYCLES=16) -> no motion from glitches. After 18 stable clocks, each tick drops paddle_r_y by 4: 196, 192, ... until clamped at wall_width=10, then stays 10.
- Hold btn_up and btn_down together -> paddle_r_y unchanged. Hold btn_down (length=80, wall=10) -> clamps at 390.
- ball_direction 0->1 with ball_y=50, ball_width=8, length=80 -> ai_state 1 for 6 ticks, then 2. paddle_l_y steps 200,197,... and settles within 4 of target 14 (clamped to 10 if below).
- In TRACK, set ball_direction=0 -> next tick ai_state=0. paddle_l_y returns by 3/tick to 200 exactly, no overshoot.
- Drive reset=0 mid-TRACK between clock edges -> outputs read RESET_Y and ai_state=0 without waiting for a clock edge.
